// File: rtl/sim_seq_pkg.sv
// Shared types and seed stepping for the run-level sequencer.
// Seed stepping keeps the LFSR seed non-zero.
package sim_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RESET_DP,
      S_LOAD_INH,
      S_START,
      S_RUN,
      S_RESULT,
      S_DONE
   } seq_state_e;

   localparam logic [63:0] SEED_STEP = 64'h9E3779B97F4A7C15;

   function automatic logic [63:0] next_seed(input logic [63:0] s);
      logic [63:0] n;
      n = s + SEED_STEP;
      return (n == 64'd0) ? 64'd1 : n;
   endfunction

endpackage

// File: rtl/sim_run_sequencer.sv
// Run-level controller: per run resets the datapath, loads inhibitors,
// starts it, waits for steady/timeout and hands one result to the host.
module sim_run_sequencer
   import sim_seq_pkg::*;
#(
   parameter int RULES     = 32,
   parameter int LOG_RULES = 5,
   parameter int LOG_ITER  = 16,
   parameter int MAX_INHIB = 4,
   parameter int RUNS_W    = 8,
   localparam int CNT_W    = $clog2(MAX_INHIB + 1)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           cmd_valid,
   output logic                           cmd_ready,
   input  logic [RUNS_W-1:0]              cmd_runs,
   input  logic [63:0]                    cmd_seed,
   input  logic [CNT_W-1:0]               cmd_inhib_cnt,
   input  logic [MAX_INHIB*LOG_RULES-1:0] cmd_inhib_list,
   input  logic [LOG_ITER-1:0]            cmd_iter_limit,
   output logic                           dp_rst,
   output logic [63:0]                    dp_seed,
   output logic                           dp_ld_inhibitor,
   output logic [LOG_RULES-1:0]           dp_sel_inhibitor,
   output logic                           dp_start,
   input  logic [RULES-1:0]               dp_network_state,
   input  logic                           dp_steady_state,
   input  logic [LOG_ITER-1:0]            dp_iteration_number,
   output logic                           res_valid,
   input  logic                           res_ready,
   output logic [RULES-1:0]               res_state,
   output logic [LOG_ITER-1:0]            res_iter,
   output logic                           res_steady,
   output logic [RUNS_W-1:0]              res_run_idx,
   output logic                           busy,
   output logic                           done
);

   seq_state_e                     state_q, state_d;
   logic [RUNS_W-1:0]              runs_q, runs_d;
   logic [RUNS_W-1:0]              run_idx_q, run_idx_d;
   logic [63:0]                    seed_q, seed_d;
   logic [CNT_W-1:0]               cnt_q, cnt_d;
   logic [CNT_W-1:0]               k_q, k_d;
   logic [MAX_INHIB*LOG_RULES-1:0] list_q, list_d;
   logic [LOG_ITER-1:0]            limit_q, limit_d;
   logic [RULES-1:0]               rstate_q, rstate_d;
   logic [LOG_ITER-1:0]            riter_q, riter_d;
   logic                           rsteady_q, rsteady_d;
   logic                           run_exit;
   logic                           last_run;

   assign run_exit = dp_steady_state ||
                     ((limit_q != '0) && (dp_iteration_number >= limit_q));
   assign last_run = (RUNS_W'(run_idx_q + 1'b1) == runs_q);

   always_comb begin
      state_d   = state_q;
      runs_d    = runs_q;
      run_idx_d = run_idx_q;
      seed_d    = seed_q;
      cnt_d     = cnt_q;
      k_d       = k_q;
      list_d    = list_q;
      limit_d   = limit_q;
      rstate_d  = rstate_q;
      riter_d   = riter_q;
      rsteady_d = rsteady_q;
      unique case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               runs_d    = cmd_runs;
               run_idx_d = '0;
               seed_d    = (cmd_seed == 64'd0) ? 64'd1 : cmd_seed;
               cnt_d     = (cmd_inhib_cnt > CNT_W'(MAX_INHIB)) ?
                           CNT_W'(MAX_INHIB) : cmd_inhib_cnt;
               list_d    = cmd_inhib_list;
               limit_d   = cmd_iter_limit;
               state_d   = (cmd_runs == '0) ? S_DONE : S_RESET_DP;
            end
         end
         S_RESET_DP: begin
            k_d     = '0;
            state_d = (cnt_q == '0) ? S_START : S_LOAD_INH;
         end
         S_LOAD_INH: begin
            if (k_q == cnt_q - 1'b1) state_d = S_START;
            else                     k_d     = k_q + 1'b1;
         end
         S_START: state_d = S_RUN;
         S_RUN: begin
            if (run_exit) begin
               rstate_d  = dp_network_state;
               riter_d   = dp_iteration_number;
               rsteady_d = dp_steady_state;
               state_d   = S_RESULT;
            end
         end
         S_RESULT: begin
            if (res_ready) begin
               if (last_run) begin
                  state_d = S_DONE;
               end else begin
                  run_idx_d = run_idx_q + 1'b1;
                  seed_d    = next_seed(seed_q);
                  state_d   = S_RESET_DP;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         runs_q    <= '0;
         run_idx_q <= '0;
         seed_q    <= '0;
         cnt_q     <= '0;
         k_q       <= '0;
         list_q    <= '0;
         limit_q   <= '0;
         rstate_q  <= '0;
         riter_q   <= '0;
         rsteady_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         runs_q    <= runs_d;
         run_idx_q <= run_idx_d;
         seed_q    <= seed_d;
         cnt_q     <= cnt_d;
         k_q       <= k_d;
         list_q    <= list_d;
         limit_q   <= limit_d;
         rstate_q  <= rstate_d;
         riter_q   <= riter_d;
         rsteady_q <= rsteady_d;
      end
   end

   // Outputs are forced quiet while rst is high, except the datapath reset.
   assign dp_rst           = rst || (state_q == S_RESET_DP);
   assign cmd_ready        = !rst && (state_q == S_IDLE);
   assign busy             = !rst && (state_q != S_IDLE);
   assign dp_ld_inhibitor  = !rst && (state_q == S_LOAD_INH);
   assign dp_sel_inhibitor = dp_ld_inhibitor ?
                             list_q[int'(k_q)*LOG_RULES +: LOG_RULES] : '0;
   assign dp_start         = !rst && (state_q == S_START);
   assign res_valid        = !rst && (state_q == S_RESULT);
   assign done             = !rst && (state_q == S_DONE);
   assign dp_seed          = rst ? '0 : seed_q;
   assign res_state        = rst ? '0 : rstate_q;
   assign res_iter         = rst ? '0 : riter_q;
   assign res_steady       = !rst && rsteady_q;
   assign res_run_idx      = rst ? '0 : run_idx_q;

endmodule

// File: tb/tb_sim_run_sequencer.sv
// Randomized bench for sim_run_sequencer with a behavioural datapath
// stub and a per-run expected-result model.
module tb_sim_run_sequencer;

   logic        clk = 0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [7:0]  cmd_runs;
   logic [63:0] cmd_seed;
   logic [2:0]  cmd_inhib_cnt;
   logic [19:0] cmd_inhib_list;
   logic [15:0] cmd_iter_limit;
   logic        dp_rst;
   logic [63:0] dp_seed;
   logic        dp_ld_inhibitor;
   logic [4:0]  dp_sel_inhibitor;
   logic        dp_start;
   logic [31:0] dp_network_state;
   logic        dp_steady_state;
   logic [15:0] dp_iteration_number;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] res_state;
   logic [15:0] res_iter;
   logic        res_steady;
   logic [7:0]  res_run_idx;
   logic        busy;
   logic        done;

   localparam logic [63:0] K = 64'h9E3779B97F4A7C15;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   sim_run_sequencer dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_runs(cmd_runs), .cmd_seed(cmd_seed),
      .cmd_inhib_cnt(cmd_inhib_cnt), .cmd_inhib_list(cmd_inhib_list),
      .cmd_iter_limit(cmd_iter_limit),
      .dp_rst(dp_rst), .dp_seed(dp_seed),
      .dp_ld_inhibitor(dp_ld_inhibitor), .dp_sel_inhibitor(dp_sel_inhibitor),
      .dp_start(dp_start), .dp_network_state(dp_network_state),
      .dp_steady_state(dp_steady_state),
      .dp_iteration_number(dp_iteration_number),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_state(res_state), .res_iter(res_iter),
      .res_steady(res_steady), .res_run_idx(res_run_idx),
      .busy(busy), .done(done)
   );

   // Datapath stub: counts iterations after start, goes steady at steady_at.
   logic [63:0] stub_seed;
   logic        stub_run;
   logic [15:0] stub_it;
   int          steady_at;
   int          st_tab[8];

   always @(posedge clk) begin
      if (dp_rst) begin
         stub_run  <= 1'b0;
         stub_it   <= '0;
         stub_seed <= dp_seed;
      end else if (dp_start) begin
         stub_run <= 1'b1;
         stub_it  <= '0;
      end else if (stub_run && !dp_steady_state) begin
         stub_it <= stub_it + 1'b1;
      end
   end

   assign dp_steady_state = stub_run && (steady_at != 0) &&
                            (int'(stub_it) >= steady_at);
   assign dp_iteration_number = stub_it;
   assign dp_network_state = stub_seed[31:0] + 32'(stub_it) * 32'd3;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic run_batch(input int runs, input logic [63:0] seed,
                            input int cnt, input logic [19:0] list,
                            input int limit, input int stall_run);
      logic [63:0] exp_seed;
      logic [19:0] tmp;
      int c, run, ld, ncnt, starts, s_cyc, hs_cyc, rst_cyc;
      int stall_left, ei, es;
      bit first, got_done;
      @(negedge clk);
      check("cmd_ready", cmd_ready, 1);
      cmd_runs       = 8'(runs);
      cmd_seed       = seed;
      cmd_inhib_cnt  = 3'(cnt);
      cmd_inhib_list = list;
      cmd_iter_limit = 16'(limit);
      cmd_valid      = 1;
      res_ready      = 0;
      @(negedge clk);
      cmd_valid = 0;
      c = 1; run = 0; ld = 0; starts = 0;
      s_cyc = 0; hs_cyc = -1; rst_cyc = 0;
      ncnt = (cnt > 4) ? 4 : cnt;
      exp_seed = (seed == 0) ? 64'd1 : seed;
      first = 1; got_done = 0; stall_left = 0;
      while (c < 2000 && !got_done) begin
         if (dp_rst) begin
            check("seed_at_rst", dp_seed, exp_seed);
            if (run == 0) check("rst_cycle", c, 1);
            else check("rst_after_hs", c, hs_cyc + 1);
            rst_cyc = c; ld = 0;
            steady_at = st_tab[run];
         end
         if (dp_ld_inhibitor) begin
            tmp = list >> (ld * 5);
            check("sel", dp_sel_inhibitor, tmp[4:0]);
            ld++;
         end
         if (dp_start) begin
            check("ld_count", ld, ncnt);
            check("start_cycle", c - rst_cyc, 1 + ncnt);
            check("seed_at_start", dp_seed, exp_seed);
            s_cyc = c;
            starts++;
         end
         res_ready = 0;
         if (res_valid) begin
            if (st_tab[run] != 0 && (limit == 0 || st_tab[run] <= limit)) begin
               ei = st_tab[run]; es = 1;
            end else begin
               ei = limit; es = 0;
            end
            check("res_iter", res_iter, ei);
            check("res_steady", res_steady, es);
            check("res_run_idx", res_run_idx, run);
            check("res_state", res_state, exp_seed[31:0] + 32'(ei) * 32'd3);
            if (first) begin
               check("res_latency", c, s_cyc + 2 + ei);
               first = 0;
               stall_left = (run == stall_run) ? 10 : $urandom_range(0, 2);
            end
            if (stall_left > 0) begin
               stall_left--;
            end else begin
               res_ready = 1;
               hs_cyc = c;
               run++;
               first = 1;
               exp_seed = exp_seed + K;
               if (exp_seed == 0) exp_seed = 64'd1;
            end
         end
         if (done) begin
            check("done_runs", run, runs);
            check("done_starts", starts, runs);
            if (runs == 0) check("done_cycle", c, 1);
            else check("done_after_hs", c, hs_cyc + 1);
            got_done = 1;
         end
         @(negedge clk);
         c++;
      end
      res_ready = 0;
      if (!got_done) check("batch_timeout", 0, 1);
   endtask

   initial begin
      int n;
      bit seen_done;
      rst = 1; cmd_valid = 0; res_ready = 0;
      cmd_runs = 0; cmd_seed = 0; cmd_inhib_cnt = 0;
      cmd_inhib_list = 0; cmd_iter_limit = 0;
      steady_at = 0;
      foreach (st_tab[i]) st_tab[i] = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_dp_rst", dp_rst, 1);
         check("rst_busy", busy, 0);
      end
      rst = 0;
      @(negedge clk);
      check("rel_cmd_ready", cmd_ready, 1);
      check("rel_dp_rst", dp_rst, 0);
      check("rel_outs", {busy, done, res_valid, dp_start, dp_ld_inhibitor}, 0);
      check("rel_seed", dp_seed, 0);
      check("rel_res", {res_state, res_iter, res_run_idx}, 0);

      st_tab[0] = 12;
      run_batch(1, 64'd5, 2, 20'h000E3, 0, -1);

      st_tab[0] = 3; st_tab[1] = 5; st_tab[2] = 2;
      run_batch(3, 64'd5, 0, 20'h0, 0, 1);

      st_tab[0] = 0;
      run_batch(1, 64'd9, 1, 20'h0001F, 4, -1);
      st_tab[0] = 4;
      run_batch(1, 64'd9, 0, 20'h0, 4, -1);

      run_batch(0, 64'd0, 0, 20'h0, 0, -1);
      st_tab[0] = 2;
      run_batch(1, 64'd0, 6, 20'hABCDE, 0, -1);

      // Reset while a run is in progress.
      st_tab[0] = 0;
      cmd_runs = 2; cmd_seed = 64'd77; cmd_inhib_cnt = 0;
      cmd_iter_limit = 0; cmd_valid = 1;
      @(negedge clk);
      cmd_valid = 0;
      n = 0;
      while (!dp_start && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("mid_start_seen", dp_start, 1);
      repeat (3) @(negedge clk);
      rst = 1;
      @(negedge clk);
      check("mid_dp_rst", dp_rst, 1);
      check("mid_busy", busy, 0);
      rst = 0;
      @(negedge clk);
      check("mid_idle", cmd_ready, 1);
      check("mid_res_valid", res_valid, 0);
      seen_done = 0;
      for (int i = 0; i < 5; i++) begin
         if (done || busy) seen_done = 1;
         @(negedge clk);
      end
      check("mid_no_done", seen_done, 0);
      st_tab[0] = 6; st_tab[1] = 1;
      run_batch(2, 64'd77, 3, 20'h12345, 0, -1);

      for (int b = 0; b < 20; b++) begin
         int runs, lim;
         runs = $urandom_range(1, 4);
         lim  = $urandom_range(0, 8);
         for (int r = 0; r < 8; r++)
            st_tab[r] = (lim == 0) ? $urandom_range(1, 10) : $urandom_range(0, 10);
         run_batch(runs, {$urandom, $urandom}, $urandom_range(0, 7),
                   20'($urandom), lim, $urandom_range(0, 3));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sim_run_sequencer.md
# sim_run_sequencer

Run-level controller for the asynchronous-update network simulation datapath. Accepts a batch command (run count, base seed, inhibitor list, iteration limit) and, per run: resets the datapath, loads the inhibitor mask one rule per cycle, pulses start, and waits for steady state or the iteration limit. It then hands one result record per run to the host over a valid/ready channel. It sits between the host/config interface and one datapath instance.

## Interface
Parameters:
- RULES, 32, network state width
- LOG_RULES, 5, rule-index width
- LOG_ITER, 16, iteration counter width
- MAX_INHIB, 4, max inhibited rules per batch
- RUNS_W, 8, run-count width

Ports:
- clk  in  1  system clock
- rst  in  1  one clock; reset is synchronous and active-high
- cmd_valid  in  1  batch command valid
- cmd_ready  out  1  high only in IDLE
- cmd_runs  in  RUNS_W  number of runs; 0 = no runs
- cmd_seed  in  64  base LFSR seed
- cmd_inhib_cnt  in  $clog2(MAX_INHIB+1)  valid entries in list, clamped to MAX_INHIB
- cmd_inhib_list  in  MAX_INHIB*LOG_RULES  rule indices, entry 0 in LSBs
- cmd_iter_limit  in  LOG_ITER  timeout iteration; 0 = unlimited
- dp_rst  out  1  datapath reset (rst OR state RESET_DP)
- dp_seed  out  64  seed for current run
- dp_ld_inhibitor  out  1  inhibitor load strobe
- dp_sel_inhibitor  out  LOG_RULES  rule being inhibited
- dp_start  out  1  one-cycle start pulse
- dp_network_state  in  RULES  datapath state
- dp_steady_state  in  1  datapath steady flag
- dp_iteration_number  in  LOG_ITER  datapath iteration count
- res_valid  out  1  result record valid
- res_ready  in  1  host accepts record
- res_state  out  RULES  captured network state
- res_iter  out  LOG_ITER  captured iteration number
- res_steady  out  1  1 = steady, 0 = timeout
- res_run_idx  out  RUNS_W  run index, 0-based
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse at end of batch

## Operation
- States: IDLE, RESET_DP, LOAD_INH, START, RUN, RESULT, DONE.
- IDLE: cmd_ready=1. On cmd_valid, latch all cmd fields and set run_idx=0, seed_reg=cmd_seed (0 is replaced by 1).
  - cmd_runs=0: go to DONE.
  - Otherwise: go to RESET_DP.
- RESET_DP (1 cycle): dp_rst=1; dp_seed=seed_reg. Datapath clears its state and inhibitor mask.
- LOAD_INH: one entry per cycle, k=0..inhib_cnt-1, with dp_ld_inhibitor=1 and dp_sel_inhibitor=list[k]. Skipped if inhib_cnt=0.
- START (1 cycle): dp_start=1.
- RUN: exit when dp_steady_state=1, or when iter_limit≠0 and dp_iteration_number≥iter_limit.
  - Capture res_state, res_iter and res_steady (=dp_steady_state) on exit.
  - If both conditions hold in the same cycle, res_steady=1.
- RESULT: res_valid=1, with payload held stable until res_ready. On the handshake:
  - run_idx==runs-1: go to DONE.
  - Otherwise: run_idx+=1, seed_reg = seed_reg + 64'h9E3779B97F4A7C15 (mod 2^64, 0 replaced by 1), then go to RESET_DP.
- DONE (1 cycle): done=1, then IDLE.
- Reset mid-operation: return to IDLE and zero every output except dp_rst=1. Partial results are discarded.

## Timing
- Reset values: cmd_ready=1 after release; all other outputs 0; dp_rst=1 while rst is high.
- Command accepted in cycle T. RESET_DP at T+1; LOAD_INH at T+2..T+1+n; START at T+2+n; RUN from T+3+n.
- res_valid rises the cycle after the exit condition is sampled.
- Next run's RESET_DP starts the cycle after the res_valid&&res_ready handshake.
- done pulses the cycle after the final handshake.
- dp_seed is stable from RESET_DP through the end of RUN.

## Structure
- Package sim_seq_pkg holds:
  - the state enum;
  - the seed-step constant 64'h9E3779B97F4A7C15;
  - the function next_seed(), which applies the zero→1 fix.
- Single module; no sub-module needed.
- Existing register/comparator primitives may be reused for the result capture and the limit compare.

## Test plan
- Reset held 3 cycles, then released. dp_rst=1 during reset; cmd_ready=1 and all other outputs 0 afterwards.
- runs=1, inhib_cnt=2, list={3,7}, seed=5, limit=0. Exactly 2 dp_ld_inhibitor cycles with sel 3 then 7; dp_start at T+4. On steady at iter 12: res_iter=12, res_steady=1, res_run_idx=0, then done.
- runs=3, res_ready low for 10 cycles on run 1. Payload stays stable; dp_seed values are 5, 5+K and 5+2K; res_run_idx is 0, 1, 2.
- limit=4 with a datapath that never reaches steady. Exit at iteration_number=4 with res_steady=0. A case where steady and limit coincide gives res_steady=1.
- cmd_runs=0: done pulses at T+1 with no dp_start. cmd_seed=0 drives dp_seed=1.
- rst asserted during RUN: the next cycle is IDLE with res_valid=0 and no done pulse. A new command then runs normally.
